// File: rtl/tis_pkg.sv
// Shared TIS types: word width, port-index helper and arbiter state encoding.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package tis_pkg;

  localparam int WORD_W = 11;
  typedef logic [WORD_W-1:0] word_t;

  // Default producer count on a node and the index width derived from it.
  localparam int NPORTS = 4;

  // Index width for n ports; never narrower than one bit so N=1 still has a port.
  function automatic int src_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int SRC_W = src_w(NPORTS);
  typedef logic [SRC_W-1:0] src_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the caller decides when the pick is used.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          valid_o,
  output logic [IW-1:0] idx_o
);

  logic [IW-1:0] cand;

  // Walk from the farthest offset down to ptr so the nearest requester is the last write.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = IW'((int'(ptr_i) + i) % N);
      if (req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/port_arbiter.sv
// Round-robin arbiter draining N read-pulse producers into one registered output port.
// Latency: word offered one cycle after arbitration; one word per 3 cycles at best.
// Backpressure: holds the captured word until out_read; producers are not drained meanwhile.
module port_arbiter
  import tis_pkg::*;
#(
  parameter int N  = NPORTS,
  parameter int W  = WORD_W,
  parameter int IW = src_w(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      rready_i,
  input  logic [N-1:0][W-1:0] in_i,
  output logic [N-1:0]      read_o,
  output logic              out_rready,
  output logic [W-1:0]      out_value,
  output logic [IW-1:0]     out_src,
  input  logic              out_read,
  output logic [15:0]       xfer_count
);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  read_q, read_d;
  logic          rdy_q, rdy_d;
  logic [W-1:0]  val_q, val_d;
  logic [IW-1:0] src_q, src_d;
  logic [15:0]   xfer_q, xfer_d;

  logic          pick_vld;
  logic [IW-1:0] pick_idx;

  rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req_i   (rready_i),
    .ptr_i   (ptr_q),
    .valid_o (pick_vld),
    .idx_o   (pick_idx)
  );

  // Next state: capture a winner in IDLE, wait for the downstream consume pulse in HOLD.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    read_d  = '0;
    rdy_d   = rdy_q;
    val_d   = val_q;
    src_d   = src_q;
    xfer_d  = xfer_q;
    case (state_q)
      ST_IDLE: begin
        // A consume pulse here has nothing to consume and is dropped.
        if (pick_vld) begin
          read_d[pick_idx] = 1'b1;
          val_d            = in_i[pick_idx];
          src_d            = pick_idx;
          rdy_d            = 1'b1;
          ptr_d            = (pick_idx == IW'(N - 1)) ? '0 : pick_idx + 1'b1;
          state_d          = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // Producers are ignored here; only the downstream pulse moves us on.
        if (out_read) begin
          rdy_d   = 1'b0;
          xfer_d  = xfer_q + 16'd1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset mid-HOLD drops the captured word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      read_q  <= '0;
      rdy_q   <= 1'b0;
      val_q   <= '0;
      src_q   <= '0;
      xfer_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      read_q  <= read_d;
      rdy_q   <= rdy_d;
      val_q   <= val_d;
      src_q   <= src_d;
      xfer_q  <= xfer_d;
    end
  end

  assign read_o     = read_q;
  assign out_rready = rdy_q;
  assign out_value  = val_q;
  assign out_src    = src_q;
  assign xfer_count = xfer_q;

endmodule

// File: doc/port_arbiter.md
# port_arbiter

Round-robin arbiter that shares one downstream consumer among N producer ports using the single-cycle `read` pulse handshake. It drains a producer exactly as a sink does: it samples `rready`, captures the word and pulses `read` back. It then re-offers the captured word, tagged with its source index, on one output port that a sink or a node input drains. The block sits between the node output ports and the shared output/debug sink.

## Interface
- `N`, 4: number of producer ports, ≥1
- `W`, 11: data word width (TIS word, -999..999 in two's complement)
- `IW`, `$clog2(N)` (min 1): source index width
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `rready_i`  in  N  producer p has a word available
- `in_i`  in  N×W  producer words, `in_i[p]` valid while `rready_i[p]`
- `read_o`  out  N  one-cycle consume pulse to producer p
- `out_rready`  out  1  captured word available downstream
- `out_value`  out  W  captured word
- `out_src`  out  IW  index of the producer the word came from
- `out_read`  in  1  one-cycle consume pulse from downstream
- `xfer_count`  out  16  words delivered downstream

## Operation
- Reset values are all 0: `read_o`, `out_rready`, `out_value`, `out_src`, `xfer_count`, round-robin pointer `ptr`, and state (IDLE).
- States:
  - IDLE
    - If any `rready_i` is sampled high, pick winner `w` = first set bit searching from `ptr` upward, wrapping modulo N.
    - Register `read_o[w]`←1, `out_value`←`in_i[w]`, `out_src`←`w`, `out_rready`←1, `ptr`←(w+1) mod N.
    - Go to HOLD.
    - Otherwise stay in IDLE.
  - HOLD
    - `read_o` returns to 0 after exactly one cycle.
    - `out_value` and `out_src` stay stable.
    - When `out_read` is sampled high: `out_rready`←0, `xfer_count`←`xfer_count`+1 (wraps 65535→0), go to IDLE.
- Only one `read_o` bit is ever high, and only for one cycle per captured word.
- `out_read` sampled in IDLE is ignored: no count change, no state change.
- Producers must deassert `rready_i` within one cycle of their `read_o` pulse. The block does not re-check this.
- `rready_i` changes during HOLD are ignored. Arbitration happens only in IDLE.
- With N=1, `ptr` and `out_src` are constant 0.
- Reset asserted mid-HOLD discards the captured word. The producer has already been consumed, so the word is lost by design.

## Timing
- Arbitration decision is made at edge k, when `rready_i` is sampled in IDLE.
- In cycle k+1, `read_o[w]` and `out_rready` are high together.
- Earliest downstream consume: a sink samples `out_rready` at edge k+1 and pulses `out_read` in cycle k+2. The block samples it at edge k+2 and is back in IDLE in cycle k+3.
- Minimum spacing between successive `read_o` pulses is 3 cycles. Peak throughput is one word per 3 cycles.
- If HOLD is entered while `out_read` is already high (stale pulse), it is not honoured. HOLD requires `out_read` sampled in a cycle where `out_rready` is already high.
- Outputs are registered. The only combinational path is the `rready_i` → winner pick into registers.

## Structure
- Shared package `tis_pkg` holds:
  - `WORD_W` = 11
  - `typedef logic [WORD_W-1:0] word_t`
  - the `out_src` index typedef helper
- One sub-module, `rr_pick`: combinational round-robin picker.
  - Inputs: request vector (N) and `ptr`.
  - Outputs: `valid` and winner index.
  - Parameterised by N.
- FSM, capture registers and counter live in `port_arbiter`.

## Test plan
- **Reset:** assert `rst` mid-HOLD with `out_rready`=1 → all outputs 0 asynchronously; after release, IDLE with `ptr`=0.
- **Single producer:** `rready_i`=4'b0100, `in_i[2]`=11'd999 →
  - cycle k+1: `read_o`=4'b0100, `out_rready`=1, `out_value`=999, `out_src`=2
  - `out_read` pulse → `out_rready`=0, `xfer_count`=1
- **Fairness:** all four `rready_i` held high, each producer re-asserting after its consume → grant order 0,1,2,3,0 and exactly one `read_o` bit per grant.
- **Wrap:** `ptr`=3, requests on ports 1 and 3 → 3 wins, then 1. Next, with `ptr`=2 and a request only on 1 → 1 wins.
- **Stalled downstream:** no `out_read` for 20 cycles while other `rready_i` are high → no further `read_o`, `out_value` stable.
- **Stray handshake:** `out_read` pulsed in IDLE → no state change.
- **Counter wrap:** force `xfer_count`=65535, then one delivery → 0.
